// File: rtl/rv_pkg.sv
// Shared constants and types for the RISC-V integer datapath.
//   XLEN       : default datapath width
//   REG_ADDR_W : architectural register index width
//   X0         : index of the hard-wired zero register
package rv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t X0 = '0;
endpackage

// File: rtl/wb_regfile_if.sv
// Writeback / register-file bus between the MEM/WB register, decode stage,
// forwarding unit and debug port.
//   memwb_*      : writeback request from MEM/WB
//   rs1/rs2_*    : decode read ports
//   wb_data/wb_we: selected writeback value and effective strobe
//   dbg_*        : stored-value debug read
//   retire_count : committed write count
// slave = register file side, master = pipeline / bench side.
interface wb_regfile_if #(parameter int XLEN = 32);
  logic [XLEN-1:0]   memwb_read_data_datamem;
  logic [XLEN-1:0]   memwb_aluresult;
  rv_pkg::reg_idx_t  memwb_rd;
  logic              memwb_regwrite;
  logic              memwb_memtoreg;
  rv_pkg::reg_idx_t  rs1_addr;
  rv_pkg::reg_idx_t  rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   wb_data;
  logic              wb_we;
  rv_pkg::reg_idx_t  dbg_addr;
  logic [XLEN-1:0]   dbg_data;
  logic [31:0]       retire_count;

  modport slave (
    input  memwb_read_data_datamem, memwb_aluresult, memwb_rd,
           memwb_regwrite, memwb_memtoreg, rs1_addr, rs2_addr, dbg_addr,
    output rs1_data, rs2_data, wb_data, wb_we, dbg_data, retire_count
  );

  modport master (
    output memwb_read_data_datamem, memwb_aluresult, memwb_rd,
           memwb_regwrite, memwb_memtoreg, rs1_addr, rs2_addr, dbg_addr,
    input  rs1_data, rs2_data, wb_data, wb_we, dbg_data, retire_count
  );
endinterface

// File: rtl/regfile_core.sv
// Architectural register storage x1..x(NREGS-1); x0 is not stored.
//   clk, rst_n : clock, async active-low clear of all entries
//   i_we/i_waddr/i_wdata : single write port
//   i_raddr/o_rdata      : NRP raw read ports, no bypass, index 0 reads 0
module regfile_core
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRP   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_we,
  input  reg_idx_t                  i_waddr,
  input  logic [XLEN-1:0]           i_wdata,
  input  reg_idx_t [NRP-1:0]        i_raddr,
  output logic [NRP-1:0][XLEN-1:0]  o_rdata
);

  logic [NREGS-1:1][XLEN-1:0] r_regs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
    end else if (i_we) begin
      for (int i = 1; i < NREGS; i++)
        if (i_waddr == reg_idx_t'(i)) r_regs[i] <= i_wdata;
    end
  end

  // Index 0 (and any index past NREGS-1) matches no entry and reads 0.
  always_comb begin
    o_rdata = '0;
    for (int p = 0; p < NRP; p++)
      for (int i = 1; i < NREGS; i++)
        if (i_raddr[p] == reg_idx_t'(i)) o_rdata[p] = r_regs[i];
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage + integer register file.
//   clk, rst_n : pipeline clock, async active-low reset
//   bus        : wb_regfile_if.slave (writeback request, read ports,
//                wb_data/wb_we to forwarding, debug read, retire_count)
// BYPASS_EN=1 forwards the in-flight writeback to rs1/rs2 in the same cycle;
// the debug port always shows stored state.
module wb_regfile
  import rv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_regfile_if.slave   bus
);

  localparam int NRD = 2;  // decode read ports that can bypass

  logic [XLEN-1:0]          w_wb_data;
  logic                     w_we;
  reg_idx_t [2:0]           w_raddr;
  logic [2:0][XLEN-1:0]     w_raw;
  logic [NRD-1:0][XLEN-1:0] w_rd_out;
  logic [31:0]              r_retire_count;

  assign w_wb_data = bus.memwb_memtoreg ? bus.memwb_read_data_datamem
                                        : bus.memwb_aluresult;
  assign w_we      = bus.memwb_regwrite && (bus.memwb_rd != X0);

  // Port order: [0]=rs1, [1]=rs2, [2]=debug.
  assign w_raddr = {bus.dbg_addr, bus.rs2_addr, bus.rs1_addr};

  regfile_core #(.XLEN(XLEN), .NREGS(NREGS), .NRP(3)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (bus.memwb_rd),
    .i_wdata (w_wb_data),
    .i_raddr (w_raddr),
    .o_rdata (w_raw)
  );

  // w_we already excludes rd=0, so a match never bypasses onto x0.
  for (genvar p = 0; p < NRD; p++) begin : g_byp
    assign w_rd_out[p] = (BYPASS_EN && w_we && (w_raddr[p] == bus.memwb_rd))
                         ? w_wb_data : w_raw[p];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_retire_count <= '0;
    else if (w_we) r_retire_count <= r_retire_count + 32'd1;
  end

  assign bus.wb_data      = w_wb_data;
  assign bus.wb_we        = w_we;
  assign bus.rs1_data     = w_rd_out[0];
  assign bus.rs2_data     = w_rd_out[1];
  assign bus.dbg_data     = w_raw[2];
  assign bus.retire_count = r_retire_count;

endmodule
